// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Operation encoding matches the opE field driven by Execute.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

    // Two's-complement ops need magnitude capture and sign fixup.
    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_chk.sv
// Protocol checker for the multiply/divide unit; carries no logic.
// A start while busy means the hazard unit failed to stall Execute.
module muldiv_sequencer_chk (
    input logic clk,
    input logic reset,
    input logic startE,
    input logic busy
);

    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset) !(startE && busy)
    );

endmodule

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop: shift-add multiply or
// restoring-divide step over the {acc, quo} register pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] diff_s;
    logic             no_borrow_s;

    // The carry out of the add lands in the accumulator MSB after the shift.
    assign sum_s       = {1'b0, acc} + {1'b0, (quo[0] ? opnd : {WIDTH{1'b0}})};
    assign trial_s     = {acc, quo[WIDTH-1]};
    assign no_borrow_s = (trial_s >= {1'b0, opnd});
    // Only taken when no borrow, so the true difference already fits WIDTH bits.
    assign diff_s      = trial_s[WIDTH-1:0] - opnd;

    // Select the next register pair for the operation in flight.
    always_comb begin
        acc_next = acc;
        quo_next = quo;
        if (is_div) begin
            if (no_borrow_s) begin
                acc_next = diff_s;
            end else begin
                acc_next = trial_s[WIDTH-1:0];
            end
            quo_next = {quo[WIDTH-2:0], no_borrow_s};
        end else begin
            acc_next = sum_s[WIDTH:1];
            quo_next = {sum_s[0], quo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with a 32-step loop,
// a sign-fixup/commit state and a Decode stall toward the hazard unit.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             abortE,
    input  logic             mthiW,
    input  logic             mtloW,
    input  logic [WIDTH-1:0] mtdataW,
    input  logic             hlreadD,
    input  logic             muldivD,
    output logic             busy,
    output logic             stallD,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t             state_r;
    logic [MD_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]      acc_r;
    logic [WIDTH-1:0]      quo_r;
    logic [WIDTH-1:0]      opnd_r;
    logic                  is_div_r;
    logic                  negq_r;
    logic                  negr_r;
    logic [WIDTH-1:0]      hi_r;
    logic [WIDTH-1:0]      lo_r;
    logic                  busy_r;
    logic                  done_r;

    md_op_t                op_s;
    logic                  sa_s;
    logic                  sb_s;
    logic [WIDTH-1:0]      mag_a_s;
    logic [WIDTH-1:0]      mag_b_s;
    logic [WIDTH-1:0]      acc_next_s;
    logic [WIDTH-1:0]      quo_next_s;
    logic [2*WIDTH-1:0]    prod_s;
    logic [WIDTH-1:0]      quo_fix_s;
    logic [WIDTH-1:0]      rem_fix_s;

    assign op_s = md_op_t'(opE);

    // Operand magnitudes for signed ops; 0x80000000 stays as its unsigned magnitude.
    always_comb begin
        sa_s    = md_is_signed(op_s) & srcaE[WIDTH-1];
        sb_s    = md_is_signed(op_s) & srcbE[WIDTH-1];
        mag_a_s = srcaE;
        mag_b_s = srcbE;
        if (sa_s) begin
            mag_a_s = {WIDTH{1'b0}} - srcaE;
        end else begin
            mag_a_s = srcaE;
        end
        if (sb_s) begin
            mag_b_s = {WIDTH{1'b0}} - srcbE;
        end else begin
            mag_b_s = srcbE;
        end
    end

    // Sign-corrected results presented to the commit in FIX.
    always_comb begin
        prod_s    = {acc_r, quo_r};
        quo_fix_s = quo_r;
        rem_fix_s = acc_r;
        if (negq_r) begin
            prod_s    = {(2*WIDTH){1'b0}} - {acc_r, quo_r};
            quo_fix_s = {WIDTH{1'b0}} - quo_r;
        end else begin
            prod_s    = {acc_r, quo_r};
            quo_fix_s = quo_r;
        end
        if (negr_r) begin
            rem_fix_s = {WIDTH{1'b0}} - acc_r;
        end else begin
            rem_fix_s = acc_r;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .quo      (quo_r),
        .opnd     (opnd_r),
        .acc_next (acc_next_s),
        .quo_next (quo_next_s)
    );

    // Sequencer FSM, iteration datapath and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {MD_CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            negq_r   <= 1'b0;
            negr_r   <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            // mthi/mtlo first so a same-cycle commit below overrides them.
            if (mthiW) hi_r <= mtdataW;
            if (mtloW) lo_r <= mtdataW;
            case (state_r)
                IDLE: begin
                    if (startE && !abortE) begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        cnt_r    <= {MD_CNT_W{1'b0}};
                        acc_r    <= {WIDTH{1'b0}};
                        is_div_r <= opE[1];
                        negq_r   <= sa_s ^ sb_s;
                        negr_r   <= sa_s;
                        if (opE[1]) begin
                            quo_r  <= mag_a_s;
                            opnd_r <= mag_b_s;
                        end else begin
                            quo_r  <= mag_b_s;
                            opnd_r <= mag_a_s;
                        end
                    end
                end
                RUN: begin
                    if (abortE) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {MD_CNT_W{1'b0}};
                    end else begin
                        acc_r <= acc_next_s;
                        quo_r <= quo_next_s;
                        if (cnt_r == MD_CNT_W'(WIDTH - 1)) begin
                            state_r <= FIX;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + MD_CNT_W'(1);
                        end
                    end
                end
                FIX: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= {MD_CNT_W{1'b0}};
                    if (!abortE) begin
                        if (is_div_r) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end else begin
                            hi_r <= prod_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= {MD_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign stallD = busy_r & (hlreadD | muldivD);
    // A kill in FIX cancels the commit, so the pulse must drop with it.
    assign done   = done_r & ~abortE;
    assign hi     = hi_r;
    assign lo     = lo_r;

    muldiv_sequencer_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .busy   (busy_r)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic vectors, cycle timing,
// Decode stall, abort, mthi/mtlo ordering and asynchronous reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE, abortE, mthiW, mtloW, hlreadD, muldivD;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE, mtdataW;
    logic        busy, stallD, done;
    logic [31:0] hi, lo;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .abortE(abortE),
        .mthiW(mthiW), .mtloW(mtloW), .mtdataW(mtdataW),
        .hlreadD(hlreadD), .muldivD(muldivD),
        .busy(busy), .stallD(stallD), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Present a start for one edge, then scramble operands to prove capture.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        opE = op; srcaE = a; srcbE = b; startE = 1'b1;
        @(posedge clk); #1;
        startE = 1'b0; srcaE = ~a; srcbE = ~b;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
        nvec++; if (stallD !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b want 0", stallD); end
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL reset_hi got %h want 0", hi); end
        nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL reset_lo got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_arith();
        vec_t v [11];
        v[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[3]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        v[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v[5]  = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        v[6]  = '{2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        v[7]  = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        v[8]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        v[9]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        v[10] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        for (int i = 0; i < 11; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            for (int c = 1; c <= 34; c++) begin
                @(negedge clk);
                nvec++;
                if (busy !== 1'(c <= 33)) begin
                    nerr++; $display("FAIL arith%0d_busy cycle %0d got %b want %b", i, c, busy, (c <= 33));
                end
                nvec++;
                if (done !== 1'(c == 33)) begin
                    nerr++; $display("FAIL arith%0d_done cycle %0d got %b want %b", i, c, done, (c == 33));
                end
                if (c == 34) begin
                    nvec++;
                    if (hi !== v[i].hi) begin nerr++; $display("FAIL arith%0d_hi got %h want %h", i, hi, v[i].hi); end
                    nvec++;
                    if (lo !== v[i].lo) begin nerr++; $display("FAIL arith%0d_lo got %h want %h", i, lo, v[i].lo); end
                end
            end
        end
    endtask

    task automatic test_stall();
        issue(2'd1, 32'd5, 32'd6);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            nvec++;
            if (stallD !== 1'(c >= 2 && c <= 33)) begin
                nerr++; $display("FAIL stall cycle %0d got %b want %b", c, stallD, (c >= 2 && c <= 33));
            end
            if (c == 1) hlreadD = 1'b1;
            if (c == 20) begin hlreadD = 1'b0; muldivD = 1'b1; end
            if (c == 34) begin
                nvec++;
                if (lo !== 32'd30) begin nerr++; $display("FAIL stall_lo got %h want %h", lo, 32'd30); end
                nvec++;
                if (hi !== 32'd0) begin nerr++; $display("FAIL stall_hi got %h want 0", hi); end
            end
        end
        muldivD = 1'b0;
    endtask

    task automatic test_abort_run();
        issue(2'd0, 32'd2, 32'd3);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            nvec++;
            if (busy !== 1'(c <= 20)) begin nerr++; $display("FAIL abort_run_busy cycle %0d got %b want %b", c, busy, (c <= 20)); end
            nvec++;
            if (done !== 1'b0) begin nerr++; $display("FAIL abort_run_done cycle %0d got %b want 0", c, done); end
            nvec++;
            if (lo !== 32'd30 || hi !== 32'd0) begin
                nerr++; $display("FAIL abort_run_hilo cycle %0d got %h_%h want 00000000_0000001e", c, hi, lo);
            end
            if (c == 20) abortE = 1'b1;
            if (c == 21) abortE = 1'b0;
        end
    endtask

    task automatic test_abort_fix();
        issue(2'd1, 32'd7, 32'd9);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            nvec++;
            if (busy !== 1'(c <= 33)) begin nerr++; $display("FAIL abort_fix_busy cycle %0d got %b want %b", c, busy, (c <= 33)); end
            nvec++;
            if (done !== 1'b0) begin nerr++; $display("FAIL abort_fix_done cycle %0d got %b want 0", c, done); end
            if (c == 32) begin @(posedge clk); #1; abortE = 1'b1; end
            if (c == 34) begin
                abortE = 1'b0;
                nvec++;
                if (lo !== 32'd30 || hi !== 32'd0) begin
                    nerr++; $display("FAIL abort_fix_hilo got %h_%h want 00000000_0000001e", hi, lo);
                end
            end
        end
    endtask

    task automatic test_mt_order();
        issue(2'd1, 32'h00010000, 32'h00010001);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 10) begin mtloW = 1'b1; mtdataW = 32'h00001234; end
            if (c == 11) begin
                mtloW = 1'b0;
                nvec++;
                if (lo !== 32'h00001234) begin nerr++; $display("FAIL mtlo_run got %h want 00001234", lo); end
            end
            if (c == 33) begin
                nvec++;
                if (done !== 1'b1) begin nerr++; $display("FAIL mt_done got %b want 1", done); end
            end
            if (c == 32) begin @(posedge clk); #1; mthiW = 1'b1; mtloW = 1'b1; mtdataW = 32'hDEADBEEF; end
            if (c == 34) begin
                mthiW = 1'b0; mtloW = 1'b0;
                nvec++;
                if (hi !== 32'h00000001) begin nerr++; $display("FAIL mt_commit_hi got %h want 00000001", hi); end
                nvec++;
                if (lo !== 32'h00010000) begin nerr++; $display("FAIL mt_commit_lo got %h want 00010000", lo); end
            end
        end
        mthiW = 1'b1; mtdataW = 32'h0000CAFE;
        @(negedge clk);
        mthiW = 1'b0;
        nvec++;
        if (hi !== 32'h0000CAFE) begin nerr++; $display("FAIL mthi_idle got %h want 0000cafe", hi); end
    endtask

    task automatic test_reset_mid();
        issue(2'd3, 32'd100, 32'd7);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            nvec++;
            if (busy !== 1'b1) begin nerr++; $display("FAIL rst_mid_busy cycle %0d got %b want 1", c, busy); end
        end
        @(posedge clk); #1;
        reset = 1'b0; hlreadD = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy0 got %b want 0", busy); end
        nvec++; if (stallD !== 1'b0) begin nerr++; $display("FAIL rst_mid_stall got %b want 0", stallD); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_mid_done got %b want 0", done); end
        nvec++; if (hi !== 32'h0) begin nerr++; $display("FAIL rst_mid_hi got %h want 0", hi); end
        nvec++; if (lo !== 32'h0) begin nerr++; $display("FAIL rst_mid_lo got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b1; hlreadD = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_after got %b want 0", busy); end
    endtask

    initial begin
        startE = 1'b0; abortE = 1'b0; mthiW = 1'b0; mtloW = 1'b0;
        hlreadD = 1'b0; muldivD = 1'b0; opE = 2'd0;
        srcaE = 32'h0; srcbE = 32'h0; mtdataW = 32'h0;
        test_reset();
        test_arith();
        test_stall();
        test_abort_run();
        test_abort_fix();
        test_mt_order();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
